// File: rtl/jit_translate_seq.sv
// jit_translate_seq: walks ROM-linked ARM template chains for one JVM bytecode at a time.
module jit_translate_seq #(
  parameter int MAX_LEN = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_opcode,
  output logic        in_ready,
  output logic [8:0]  rom_addr,
  input  logic [6:0]  rom_data,
  output logic [6:0]  tmpl_addr,
  input  logic [32:0] tmpl_data,
  output logic        out_valid,
  output logic [31:0] out_word,
  output logic        out_last,
  input  logic        out_ready,
  input  logic        flush,
  output logic        unsupported,
  output logic        overrun,
  output logic [6:0]  word_count
);
  typedef enum logic [1:0] {IDLE, LOOKUP, FETCH, HOLD} state_t;
  localparam logic [6:0] MAX = 7'(MAX_LEN);
  state_t state, state_nx;
  logic [7:0] opcode;
  logic [6:0] cur_addr, next_addr, run;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = flush ? IDLE :
               state == IDLE   ? (in_valid ? LOOKUP : IDLE) :
               state == LOOKUP ? (rom_data == 7'd0 ? IDLE : FETCH) :
               state == FETCH  ? HOLD :
               !out_ready ? HOLD : (out_last || run >= MAX) ? IDLE : FETCH;
  always_comb begin
    in_ready  = state == IDLE && !flush;
    rom_addr  = state == LOOKUP ? {1'b0, opcode} : state == FETCH ? {2'b10, cur_addr} : 9'd0;
    tmpl_addr = state == FETCH ? cur_addr : 7'd0;
  end
  // Pulses default low every cycle; flush only drops the held word.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      opcode      <= '0;
      cur_addr    <= '0;
      next_addr   <= '0;
      run         <= '0;
      out_valid   <= 1'b0;
      out_word    <= '0;
      out_last    <= 1'b0;
      unsupported <= 1'b0;
      overrun     <= 1'b0;
      word_count  <= '0;
    end else begin
      unsupported <= 1'b0;
      overrun     <= 1'b0;
      if (flush) out_valid <= 1'b0;
      else
        case (state)
          IDLE: if (in_valid) opcode <= in_opcode;
          LOOKUP: begin
            cur_addr    <= rom_data;
            run         <= '0;
            unsupported <= rom_data == 7'd0;
          end
          FETCH: begin
            {out_last, out_word} <= tmpl_data;
            next_addr <= rom_data;
            out_valid <= 1'b1;
            run       <= run == 7'h7f ? run : run + 7'd1;
          end
          HOLD:
            if (out_ready) begin
              out_valid <= 1'b0;
              if (out_last) word_count <= run;
              else if (run < MAX) cur_addr <= next_addr;
              else overrun <= 1'b1;
            end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_jit_translate_seq.sv
// tb_jit_translate_seq: scoreboard bench with behavioural instruction-address and template ROMs.
module tb_jit_translate_seq;
  localparam int MAX_LEN = 4;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, flush = 0;
  logic [7:0] in_opcode = 0;
  logic in_ready, out_valid, out_last, unsupported, overrun;
  logic [8:0] rom_addr;
  logic [6:0] rom_data, tmpl_addr, word_count;
  logic [32:0] tmpl_data;
  logic [31:0] out_word;
  logic [6:0] irom [512];
  logic [32:0] tmpl [128];
  logic [32:0] q [$];
  int n_vec = 0, n_err = 0, n_unsup = 0, n_ovr = 0, rdy_mode = 0;
  logic [6:0] exp_wc = 0;

  jit_translate_seq #(.MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_ready(in_ready), .rom_addr(rom_addr), .rom_data(rom_data),
    .tmpl_addr(tmpl_addr), .tmpl_data(tmpl_data), .out_valid(out_valid),
    .out_word(out_word), .out_last(out_last), .out_ready(out_ready),
    .flush(flush), .unsupported(unsupported), .overrun(overrun),
    .word_count(word_count)
  );

  assign rom_data  = irom[rom_addr];
  assign tmpl_data = tmpl[tmpl_addr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ~out_ready : 1'b0;
  end

  // Every presented word must match the queue head, including every stalled cycle.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_valid", out_valid, 0);
        else begin
          chk("word", {out_last, out_word}, q[0]);
          if (out_ready) void'(q.pop_front());
        end
      end
      if (unsupported) n_unsup++;
      if (overrun) n_ovr++;
    end
  end

  task automatic start(input logic [7:0] opc);
    @(posedge clk); #1;
    in_valid = 1; in_opcode = opc;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic run_op(input logic [7:0] opc);
    logic [6:0] a;
    int n, u0, o0;
    bit eu, eo;
    a = irom[{1'b0, opc}]; eu = a == 0; eo = 0; n = 0;
    while (!eu) begin
      q.push_back(tmpl[a]);
      n++;
      if (tmpl[a][32]) begin exp_wc = 7'(n); break; end
      if (n == MAX_LEN) begin eo = 1; break; end
      a = irom[{2'b10, a}];
    end
    u0 = n_unsup; o0 = n_ovr;
    start(opc);
    @(negedge clk);
    chk("lookup_addr", rom_addr, {1'b0, opc});
    chk("lookup_busy", in_ready, 0);
    @(negedge clk);
    if (eu) begin
      chk("unsup_pulse", unsupported, 1);
      chk("unsup_ready", in_ready, 1);
    end else begin
      chk("fetch_tmpl", tmpl_addr, irom[{1'b0, opc}]);
      chk("fetch_rom", rom_addr, {2'b10, irom[{1'b0, opc}]});
      @(negedge clk);
      chk("first_valid", out_valid, 1);
    end
    for (int i = 0; i < 300; i++) begin
      if (in_ready && q.size() == 0) break;
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk("done", {in_ready, q.size() == 0}, 2'b11);
    chk("unsup_cnt", n_unsup - u0, eu);
    chk("ovr_cnt", n_ovr - o0, eo);
    chk("word_count", word_count, exp_wc);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("hold_valid", out_valid, 1);
  endtask

  initial begin
    int u0, o0;
    for (int i = 0; i < 512; i++) irom[i] = 0;
    for (int i = 0; i < 128; i++) tmpl[i] = {1'b0, 32'hE1A0_0000 + i};
    irom[11] = 11;  tmpl[11][32] = 1;
    irom[16] = 20;  irom[256+20] = 21; irom[256+21] = 22; tmpl[22][32] = 1;
    irom[32] = 30;
    for (int i = 30; i < 40; i++) irom[256+i] = 7'(i + 1);
    irom[5] = 40;   irom[256+40] = 41; tmpl[41][32] = 1;

    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_word", out_word, 0);
    chk("rst_last", out_last, 0);
    chk("rst_pulses", {unsupported, overrun}, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_addrs", {rom_addr, tmpl_addr}, 0);
    @(posedge clk); #1 rst_n = 1;

    run_op(8'h00);
    run_op(8'h0B);
    rdy_mode = 1;
    run_op(8'h10);
    rdy_mode = 0;
    run_op(8'h20);
    run_op(8'h05);
    run_op(8'hFF);

    rdy_mode = 2;
    q.push_back(tmpl[20]);
    u0 = n_unsup; o0 = n_ovr;
    start(8'h10);
    wait_valid();
    repeat (2) @(negedge clk);
    @(posedge clk); #1 flush = 1;
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    chk("flush_valid", out_valid, 0);
    chk("flush_idle", in_ready, 1);
    chk("flush_nopulse", (n_unsup - u0) + (n_ovr - o0), 0);
    chk("flush_wc", word_count, exp_wc);
    q.delete();
    rdy_mode = 0;

    @(posedge clk); #1;
    flush = 1; in_valid = 1; in_opcode = 8'h0B;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_block_ready", in_ready, 1);
    chk("flush_block_addr", rom_addr, 0);

    rdy_mode = 2;
    q.push_back(tmpl[20]);
    start(8'h10);
    wait_valid();
    @(posedge clk); #1 rst_n = 0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_word", {out_last, out_word}, 0);
    chk("midrst_wc", word_count, 0);
    chk("midrst_ready", in_ready, 1);
    q.delete();
    exp_wc = 0;
    @(posedge clk); #1 rst_n = 1;
    rdy_mode = 0;
    run_op(8'h0B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/jit_translate_seq.md
JIT_TRANSLATE_SEQ -- requirements
Module: jit_translate_seq

Interface
REQ-001 Parameter MAX_LEN, default 64, is the maximum number of template words one bytecode may emit before abort.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  bytecode opcode valid.
REQ-005 in_opcode  in  8  JVM bytecode opcode.
REQ-006 in_ready  out  1  sequencer can accept an opcode.
REQ-007 rom_addr  out  9  address to the instruction-address ROM, combinational from state.
REQ-008 rom_data  in  7  ROM response, combinational, same cycle.
REQ-009 tmpl_addr  out  7  address to the ARM template ROM, combinational from state.
REQ-010 tmpl_data  in  33  template response: [31:0] ARM word, [32] last flag.
REQ-011 out_valid  out  1  ARM word valid.
REQ-012 out_word  out  32  emitted ARM instruction word.
REQ-013 out_last  out  1  final word for the current bytecode.
REQ-014 out_ready  in  1  consumer accepts the word.
REQ-015 flush  in  1  synchronous abort of the current translation.
REQ-016 unsupported  out  1  one-cycle pulse: opcode has no template chain.
REQ-017 overrun  out  1  one-cycle pulse: chain exceeded MAX_LEN words.
REQ-018 word_count  out  7  words emitted for the last completed bytecode.

Function
REQ-019 The FSM SHALL have states IDLE, LOOKUP, FETCH, HOLD.
REQ-020 IDLE: in_ready=1; on in_valid, the sequencer SHALL latch in_opcode and go to LOOKUP.
REQ-021 LOOKUP: rom_addr SHALL equal {1'b0, opcode}; rom_data SHALL be registered into cur_addr.
REQ-022 LOOKUP with rom_data==0: unsupported SHALL pulse next cycle and the FSM SHALL return to IDLE, with no word emitted.
REQ-023 LOOKUP with rom_data!=0: the FSM SHALL go to FETCH, with run counter cleared.
REQ-024 FETCH: tmpl_addr=cur_addr and rom_addr={2'b10, cur_addr}.
REQ-025 In FETCH, out_word/out_last SHALL load tmpl_data, next_addr SHALL load rom_data, out_valid SHALL set, run counter SHALL increment, and the FSM SHALL go to HOLD.
REQ-026 HOLD: out_word, out_last and out_valid SHALL be stable until out_ready=1.
REQ-027 HOLD, on out_ready with out_last=1: out_valid SHALL clear, word_count SHALL load the run counter, and the FSM SHALL go to IDLE.
REQ-028 HOLD, on out_ready with out_last=0 and run counter<MAX_LEN: cur_addr SHALL load next_addr and the FSM SHALL go to FETCH.
REQ-029 HOLD, on out_ready with out_last=0 and run counter==MAX_LEN: overrun SHALL pulse, and the FSM SHALL go to IDLE with word_count unchanged.
REQ-030 in_ready SHALL be 0 in all states except IDLE; opcode-accept to first out_valid SHALL be exactly 3 cycles (LOOKUP, FETCH, HOLD).
REQ-031 flush SHALL have priority over all transitions: next state IDLE, out_valid=0, no pulse; a flush while in IDLE SHALL also block acceptance that cycle.
REQ-032 The run counter SHALL be 7 bits and saturate, never wrap.
REQ-033 In IDLE and HOLD, rom_addr and tmpl_addr SHALL be 0.

Reset
REQ-034 While rst_n=0, the state SHALL be IDLE, and out_valid, out_word, out_last, unsupported, overrun, word_count, cur_addr, next_addr and the run counter SHALL all be 0.
REQ-035 Reset asserted mid-chain SHALL discard the translation; after release, the sequencer SHALL accept a new opcode in IDLE.

Verification
REQ-036 Opcode 0x00 (ROM returns 0) -> unsupported pulses on cycle 2, no out_valid, in_ready=1 on cycle 2.
REQ-037 Opcode 0x0B, ROM returns 11, tmpl[11].last=1, out_ready=1 -> one word on cycle 3, out_last=1, word_count=1.
REQ-038 Three-word chain with out_ready toggling 0/1 -> each word held stable while stalled; words in chain order; word_count=3.
REQ-039 Chain with last never set, MAX_LEN=4 -> exactly 4 words, then overrun pulse, back to IDLE.
REQ-040 flush asserted in HOLD -> out_valid=0 next cycle, state IDLE, no pulse; reset asserted mid-chain -> all outputs 0 immediately.
